// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1-muxed resource.
// It drives a registered one-hot grant and the matching 2-bit mux select.
// While another requester is waiting, an owner is forced off after MAX_HOLD
// consecutive grant cycles.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // hold_cnt saturates here. With preemption disabled it saturates at all ones.
  localparam logic [HOLD_W-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);

  state_t            state_q, state_n;
  logic [1:0]        ptr_q, ptr_n;
  logic [1:0]        owner_q, owner_n;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_n;
  logic [3:0]        gnt_q, gnt_n;
  logic [1:0]        sel_q, sel_n;
  logic              preempt_q, preempt_n;

  logic [1:0]        winner;
  logic              found;
  logic [3:0]        others;
  logic              limit_hit;

  // First requesting index, scanning upward from the priority pointer.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[ptr_q + 2'(i)]) begin
        winner = ptr_q + 2'(i);
        found  = 1'b1;
      end
    end
  end

  // Contention and hold-limit detection for the current owner.
  always_comb begin
    others    = req & ~(4'b0001 << owner_q);
    limit_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_SAT) && (others != 4'b0000);
  end

  // Next-state logic. A voluntary release takes priority over a forced one.
  always_comb begin
    state_n    = state_q;
    ptr_n      = ptr_q;
    owner_n    = owner_q;
    hold_cnt_n = hold_cnt_q;
    gnt_n      = gnt_q;
    sel_n      = sel_q;
    preempt_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_n    = GRANT;
          owner_n    = winner;
          gnt_n      = 4'b0001 << winner;
          sel_n      = winner;
          hold_cnt_n = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          state_n = IDLE;
          gnt_n   = 4'b0000;
          ptr_n   = owner_q + 2'd1;
        end else if (limit_hit) begin
          state_n   = IDLE;
          gnt_n     = 4'b0000;
          ptr_n     = owner_q + 2'd1;
          preempt_n = 1'b1;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_n = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  // State register with asynchronous clear of every piece of arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      owner_q    <= 2'd0;
      hold_cnt_q <= '0;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      ptr_q      <= ptr_n;
      owner_q    <= owner_n;
      hold_cnt_q <= hold_cnt_n;
      gnt_q      <= gnt_n;
      sel_q      <= sel_n;
      preempt_q  <= preempt_n;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = |gnt_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. Expected values are queued when a step
// is driven. They are popped and compared just after the following rising edge.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  mux4_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog that stops a runaway simulation.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExpected(input logic [3:0] g, input logic [1:0] s,
                              input logic p, input string tag);
    exp_t e;
    e.gnt     = g;
    e.sel     = s;
    e.busy    = |g;
    e.preempt = p;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput();
    exp_t  e;
    exp_t  o;
    string t;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: observed no entry, expected one queued entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = '{gnt: gnt, sel: sel, busy: busy, preempt: preempt};
      vectors++;
      assert (o === e) else begin
        miscompares++;
        $error("[TB] FAIL %s: observed gnt=%b sel=%0d busy=%b preempt=%b, expected gnt=%b sel=%0d busy=%b preempt=%b",
               t, o.gnt, o.sel, o.busy, o.preempt, e.gnt, e.sel, e.busy, e.preempt);
      end
    end
  endtask

  // Drive req for the next rising edge and check the registered result after it.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] g,
                               input logic [1:0] s, input logic p, input string tag);
    @(negedge clk);
    req = r;
    pushExpected(g, s, p, tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    pushExpected(4'b0000, 2'd0, 1'b0, "reset_state");
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 1, starting from ptr=0.
    applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "single_e1_idle");
    for (int i = 0; i < 4; i++)
      applyStimulus(4'b0010, 4'b0010, 2'd1, 1'b0, "single_grant");
    applyStimulus(4'b0000, 4'b0000, 2'd1, 1'b0, "single_release");
    // Pointer is now 2, so requester 0 beats requester 1 on the wrap.
    applyStimulus(4'b0011, 4'b0001, 2'd0, 1'b0, "ptr2_wrap_to_0");
    applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "ptr2_release");

    // Grant requester 2, then reset asynchronously in the middle of the grant.
    applyStimulus(4'b0100, 4'b0100, 2'd2, 1'b0, "pre_reset_grant");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    pushExpected(4'b0000, 2'd0, 1'b0, "async_reset_midgrant");
    checkOutput();
    applyStimulus(4'b0100, 4'b0000, 2'd0, 1'b0, "reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;

    // Round robin with all four requesting. Each owner drops after 2 cycles.
    applyStimulus(4'b1111, 4'b0001, 2'd0, 1'b0, "rr_own0_c1");
    applyStimulus(4'b1111, 4'b0001, 2'd0, 1'b0, "rr_own0_c2");
    applyStimulus(4'b1110, 4'b0000, 2'd0, 1'b0, "rr_gap0");
    applyStimulus(4'b1111, 4'b0010, 2'd1, 1'b0, "rr_own1_c1");
    applyStimulus(4'b1111, 4'b0010, 2'd1, 1'b0, "rr_own1_c2");
    applyStimulus(4'b1101, 4'b0000, 2'd1, 1'b0, "rr_gap1");
    applyStimulus(4'b1111, 4'b0100, 2'd2, 1'b0, "rr_own2_c1");
    applyStimulus(4'b1111, 4'b0100, 2'd2, 1'b0, "rr_own2_c2");
    applyStimulus(4'b1011, 4'b0000, 2'd2, 1'b0, "rr_gap2");
    applyStimulus(4'b1111, 4'b1000, 2'd3, 1'b0, "rr_own3_c1");
    applyStimulus(4'b1111, 4'b1000, 2'd3, 1'b0, "rr_own3_c2");
    applyStimulus(4'b0111, 4'b0000, 2'd3, 1'b0, "rr_gap3");
    applyStimulus(4'b1111, 4'b0001, 2'd0, 1'b0, "rr_own0_again");
    applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "rr_done");

    // Preemption: requester 2 joins during owner 0's second grant cycle.
    applyStimulus(4'b0001, 4'b0001, 2'd0, 1'b0, "pre_own0_c1");
    applyStimulus(4'b0001, 4'b0001, 2'd0, 1'b0, "pre_own0_c2");
    applyStimulus(4'b0101, 4'b0001, 2'd0, 1'b0, "pre_own0_c3");
    applyStimulus(4'b0101, 4'b0001, 2'd0, 1'b0, "pre_own0_c4");
    applyStimulus(4'b0101, 4'b0000, 2'd0, 1'b1, "pre_forced_release");
    applyStimulus(4'b0101, 4'b0100, 2'd2, 1'b0, "pre_own2");
    applyStimulus(4'b0001, 4'b0000, 2'd2, 1'b0, "pre_own2_release");
    applyStimulus(4'b0000, 4'b0000, 2'd2, 1'b0, "pre_idle");

    // A lone hog is never preempted, and its hold count saturates.
    for (int i = 0; i < 20; i++)
      applyStimulus(4'b1000, 4'b1000, 2'd3, 1'b0, "hog_grant");
    vectors++;
    assert (dut.hold_cnt_q === 4'd4) else begin
      miscompares++;
      $error("[TB] FAIL hog_hold_sat: observed hold_cnt=%0d, expected 4", dut.hold_cnt_q);
    end
    applyStimulus(4'b0000, 4'b0000, 2'd3, 1'b0, "hog_release");

    // Owner 1 drops in the same cycle the limit is reached: this is a voluntary release.
    applyStimulus(4'b0010, 4'b0010, 2'd1, 1'b0, "sim_own1_c1");
    applyStimulus(4'b0011, 4'b0010, 2'd1, 1'b0, "sim_own1_c2");
    applyStimulus(4'b0011, 4'b0010, 2'd1, 1'b0, "sim_own1_c3");
    applyStimulus(4'b0011, 4'b0010, 2'd1, 1'b0, "sim_own1_c4");
    applyStimulus(4'b0001, 4'b0000, 2'd1, 1'b0, "sim_release_no_preempt");
    applyStimulus(4'b0001, 4'b0001, 2'd0, 1'b0, "sim_ptr2_wrap_own0");
    applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "sim_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
